// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate event path.
// FSM states, one-hot car selects and reject reasons.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam logic [2:0] CAR1_SEL = 3'b001;
  localparam logic [2:0] CAR2_SEL = 3'b010;
  localparam logic [2:0] CAR3_SEL = 3'b100;

  typedef enum logic [1:0] {
    RC_NONE,
    RC_BAD_REQ,
    RC_ENTER_BLOCKED,
    RC_EXIT_BLOCKED
  } rej_code_t;

  function automatic logic is_onehot(
    input logic [2:0] v
  );
    return v inside {CAR1_SEL, CAR2_SEL, CAR3_SEL};
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizer plus stable-count debouncer for one raw button.
// o_idle: pipeline fully low since reset, i.e. a real release.
module btn_debouncer
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_idle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_primed;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_btn};
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Held-through-reset buttons must not look released before
  // the synchronizer has seen them at least once.
  assign o_level = r_level;
  assign o_idle  = r_primed & ~r_level & ~|r_sync;

endmodule

// File: rtl/gate_event_generator.sv
// Turns raw gate buttons and car switches into clean
// car_sel / car_enter / car_exit events for the controller.
module gate_event_generator
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_exit,
  input  logic [2:0] sw_car,
  input  logic       car1_state,
  input  logic       car2_state,
  input  logic       car3_state,
  input  logic       full_flag,
  output logic       car_enter,
  output logic       car_exit,
  output logic [2:0] car_sel,
  output logic       reject,
  output logic [1:0] reject_code,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic       w_enter;
  logic       w_exit;
  logic       w_enter_idle;
  logic       w_exit_idle;
  logic [2:0] w_sw;
  logic       w_occ;
  logic       w_req;
  rej_code_t  w_code;
  state_t     w_nxt;

  logic [2:0] r_sw_sync [SYNC_STAGES];
  state_t     r_state;
  logic [2:0] r_car_sel;
  logic       r_dir_enter;
  logic [HW-1:0] r_hold_cnt;
  logic       r_reject;
  rej_code_t  r_reject_code;
  logic       r_busy;

  btn_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_enter (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_enter),
    .o_level(w_enter),
    .o_idle (w_enter_idle)
  );

  btn_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_exit (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_exit),
    .o_level(w_exit),
    .o_idle (w_exit_idle)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= sw_car;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sw_sync[i] <= r_sw_sync[i-1];
    end
  end

  assign w_sw  = r_sw_sync[SYNC_STAGES-1];
  assign w_req = w_enter | w_exit;
  assign w_occ = |(w_sw & {car3_state, car2_state, car1_state});

  always_comb begin
    w_code = RC_NONE;
    if ((w_enter & w_exit) | ~is_onehot(w_sw))
      w_code = RC_BAD_REQ;
    else if (w_enter & (full_flag | w_occ))
      w_code = RC_ENTER_BLOCKED;
    else if (w_exit & ~w_occ)
      w_code = RC_EXIT_BLOCKED;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_req)
          w_nxt = (w_code == RC_NONE) ? S_SETUP : S_WAIT;
      S_SETUP: w_nxt = S_PULSE;
      S_PULSE: w_nxt = S_HOLD;
      S_HOLD:
        if (r_hold_cnt == HW'(HOLD_CYCLES - 1))
          w_nxt = S_WAIT;
      S_WAIT:
        if (w_enter_idle & w_exit_idle)
          w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_car_sel     <= '0;
      r_dir_enter   <= 1'b0;
      r_hold_cnt    <= '0;
      r_reject      <= 1'b0;
      r_reject_code <= RC_NONE;
      r_busy        <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_busy   <= (w_nxt != S_IDLE);
      r_reject <= 1'b0;
      if (r_state == S_IDLE && w_req) begin
        r_reject_code <= w_code;
        if (w_code != RC_NONE) begin
          r_reject <= 1'b1;
        end else begin
          r_car_sel   <= w_sw;
          r_dir_enter <= w_enter;
        end
      end
      if (r_state == S_HOLD)
        r_hold_cnt <= r_hold_cnt + HW'(1);
      else
        r_hold_cnt <= '0;
      if (w_nxt == S_WAIT)
        r_car_sel <= '0;
    end
  end

  assign car_enter   = (r_state == S_PULSE) & r_dir_enter;
  assign car_exit    = (r_state == S_PULSE) & ~r_dir_enter;
  assign car_sel     = r_car_sel;
  assign reject      = r_reject;
  assign reject_code = r_reject_code;
  assign busy        = r_busy;

endmodule

// File: tb/tb_gate_event_generator.sv
// Randomized bench for gate_event_generator against a
// transaction-level model of the request rules and timing.
module tb_gate_event_generator;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 5;
  localparam int LAT  = SYNC + DEB + 2;

  logic       clk;
  logic       reset;
  logic       btn_enter;
  logic       btn_exit;
  logic [2:0] sw_car;
  logic       car1_state;
  logic       car2_state;
  logic       car3_state;
  logic       full_flag;
  logic       car_enter;
  logic       car_exit;
  logic [2:0] car_sel;
  logic       reject;
  logic [1:0] reject_code;
  logic       busy;

  gate_event_generator #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_enter  (btn_enter),
    .btn_exit   (btn_exit),
    .sw_car     (sw_car),
    .car1_state (car1_state),
    .car2_state (car2_state),
    .car3_state (car3_state),
    .full_flag  (full_flag),
    .car_enter  (car_enter),
    .car_exit   (car_exit),
    .car_sel    (car_sel),
    .reject     (reject),
    .reject_code(reject_code),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         n_ent, n_ext, n_rej;
  int         ent_cyc, ext_cyc;
  int         sel_first, sel_last;
  logic [2:0] sel_or, strobe_sel;
  logic [1:0] rej_seen;
  logic       busy_seen, busy_at_strobe;

  task automatic clear_mon();
    n_ent = 0; n_ext = 0; n_rej = 0;
    ent_cyc = -1; ext_cyc = -1;
    sel_first = -1; sel_last = -1;
    sel_or = '0; strobe_sel = '0; rej_seen = '0;
    busy_seen = 1'b0; busy_at_strobe = 1'b0;
  endtask

  always @(negedge clk) begin
    check("excl", car_enter & car_exit, 0);
    check("onehot", $countones(car_sel) <= 1, 1);
    if (car_enter) begin
      n_ent++; ent_cyc = cyc;
      strobe_sel = car_sel; busy_at_strobe = busy;
    end
    if (car_exit) begin
      n_ext++; ext_cyc = cyc;
      strobe_sel = car_sel; busy_at_strobe = busy;
    end
    if (reject) begin
      n_rej++; rej_seen = reject_code;
    end
    if (car_sel != 0) begin
      if (sel_first < 0) sel_first = cyc;
      sel_last = cyc;
      sel_or   = sel_or | car_sel;
    end
    busy_seen = busy_seen | busy;
  end

  function automatic int exp_code(
    input bit         e,
    input bit         x,
    input logic [2:0] sw,
    input logic [2:0] st,
    input bit         full
  );
    bit occ;
    if (e && x) return 1;
    if ($countones(sw) != 1) return 1;
    occ = (sw & st) != 0;
    if (e) return (full || occ) ? 2 : 0;
    return occ ? 0 : 3;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (!busy) break;
    end
    check({tag, "_idle"}, busy, 0);
    step(2);
  endtask

  task automatic setup_in(
    input logic [2:0] sw,
    input logic [2:0] st,
    input bit         full
  );
    step(1);
    sw_car = sw;
    {car3_state, car2_state, car1_state} = st;
    full_flag = full;
    step(4);
  endtask

  task automatic press(
    input bit         e,
    input bit         x,
    input logic [2:0] sw,
    input logic [2:0] st,
    input bit         full,
    input string      tag
  );
    int n0, code;
    setup_in(sw, st, full);
    clear_mon();
    n0 = cyc;
    btn_enter = e;
    btn_exit  = x;
    step(20);
    btn_enter = 1'b0;
    btn_exit  = 1'b0;
    wait_idle(tag);
    code = exp_code(e, x, sw, st, full);
    if (code == 0) begin
      check({tag, "_nstrobe"}, e ? n_ent : n_ext, 1);
      check({tag, "_nother"}, e ? n_ext : n_ent, 0);
      check({tag, "_tstrobe"}, e ? ent_cyc : ext_cyc,
            n0 + LAT);
      check({tag, "_ssel"}, strobe_sel, sw);
      check({tag, "_sfirst"}, sel_first, n0 + LAT - 1);
      check({tag, "_slast"}, sel_last, n0 + LAT + HOLD);
      check({tag, "_sor"}, sel_or, sw);
      check({tag, "_nrej"}, n_rej, 0);
      check({tag, "_sbusy"}, busy_at_strobe, 1);
    end else begin
      check({tag, "_nent"}, n_ent, 0);
      check({tag, "_next"}, n_ext, 0);
      check({tag, "_nrej"}, n_rej, 1);
      check({tag, "_rcode"}, rej_seen, code);
      check({tag, "_hcode"}, reject_code, code);
      check({tag, "_sor"}, sel_or, 0);
    end
  endtask

  initial begin
    int n0, r;
    bit e, x, full;
    logic [2:0] sw, st;

    reset = 1'b1;
    btn_enter = 1'b0; btn_exit = 1'b0;
    sw_car = '0; full_flag = 1'b0;
    car1_state = 1'b0; car2_state = 1'b0; car3_state = 1'b0;
    clear_mon();
    step(3);
    check("rst_enter", car_enter, 0);
    check("rst_exit", car_exit, 0);
    check("rst_sel", car_sel, 0);
    check("rst_rej", reject, 0);
    check("rst_code", reject_code, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step(5);
    check("post_rst_busy", busy, 0);

    press(1, 0, 3'b001, 3'b000, 0, "entry");
    press(1, 0, 3'b010, 3'b000, 1, "full");
    press(0, 1, 3'b100, 3'b000, 0, "exit_empty");
    press(0, 1, 3'b100, 3'b100, 0, "exit_ok");
    press(1, 0, 3'b111, 3'b000, 0, "bad_sw");
    press(1, 1, 3'b001, 3'b001, 0, "both");
    press(1, 0, 3'b010, 3'b010, 0, "occupied");

    setup_in(3'b001, 3'b000, 0);
    clear_mon();
    btn_enter = 1'b1;
    step(3);
    btn_enter = 1'b0;
    step(20);
    check("glitch_nent", n_ent, 0);
    check("glitch_nrej", n_rej, 0);
    check("glitch_busy", busy_seen, 0);

    setup_in(3'b001, 3'b000, 0);
    clear_mon();
    n0 = cyc;
    btn_enter = 1'b1;
    step(10);
    sw_car = 3'b010;
    btn_exit = 1'b1;
    step(15);
    btn_enter = 1'b0;
    btn_exit = 1'b0;
    wait_idle("ign");
    check("ign_nent", n_ent, 1);
    check("ign_next", n_ext, 0);
    check("ign_nrej", n_rej, 0);
    check("ign_sor", sel_or, 3'b001);
    check("ign_tstrobe", ent_cyc, n0 + LAT);

    setup_in(3'b001, 3'b000, 0);
    clear_mon();
    btn_enter = 1'b1;
    step(10);
    check("mid_sel", car_sel, 3'b001);
    reset = 1'b1;
    #1;
    check("arst_sel", car_sel, 0);
    check("arst_busy", busy, 0);
    check("arst_enter", car_enter, 0);
    step(2);
    reset = 1'b0;
    clear_mon();
    step(25);
    check("held_nent", n_ent, 0);
    btn_enter = 1'b0;
    wait_idle("rel");
    check("rel_nent", n_ent, 0);
    check("rel_nrej", n_rej, 0);
    press(1, 0, 3'b001, 3'b000, 0, "repress");

    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      e = (r < 5);
      x = (r == 0) || (r >= 5);
      if ($urandom_range(0, 3) == 0)
        sw = 3'($urandom);
      else
        sw = 3'b001 << $urandom_range(0, 2);
      st   = 3'($urandom);
      full = ($urandom_range(0, 3) == 0);
      press(e, x, sw, st, full, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
